// File: rtl/jh_msg_feeder_pkg.sv
// Shared constants, state encoding and the length-block builder for the JH
// message feeder.
package jh_pkg;

    localparam int BLK_W       = 512;
    localparam int WORD_W      = 64;
    localparam int LEN_FIELD_W = 128;

    localparam logic [7:0] PAD_MARK = 8'h80;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    // Final padding block: optional leading '1' bit, zeros, then the bit length.
    function automatic logic [BLK_W-1:0] len_block(input logic mark,
                                                   input logic [LEN_FIELD_W-1:0] len);
        logic [BLK_W-1:0] blk;
        blk                    = '0;
        blk[BLK_W-1]           = mark;
        blk[LEN_FIELD_W-1:0]   = len;
        return blk;
    endfunction

endpackage

// File: rtl/jh_msg_feeder_if.sv
// Message stream and hash-core block bus of the JH message feeder.
interface jh_msg_feeder_if;
    import jh_pkg::*;

    // s_data/s_last/s_nbytes transfer on a rising edge where s_valid and
    // s_ready are both high; the source holds them stable until then.
    logic [WORD_W-1:0] s_data;
    logic              s_valid;
    logic              s_ready;
    logic              s_last;
    logic [3:0]        s_nbytes;

    logic              core_en;
    logic              core_init;
    logic [BLK_W-1:0]  core_blk;
    logic              core_fin;
    logic [BLK_W-1:0]  core_odata;

    logic [BLK_W-1:0]  digest;
    logic              digest_valid;
    logic              busy;

    modport master (
        output s_data, s_valid, s_last, s_nbytes, core_fin, core_odata,
        input  s_ready, core_en, core_init, core_blk, digest, digest_valid, busy
    );

    modport slave (
        input  s_data, s_valid, s_last, s_nbytes, core_fin, core_odata,
        output s_ready, core_en, core_init, core_blk, digest, digest_valid, busy
    );

endinterface

// File: rtl/jh_msg_feeder_word_pad.sv
// Masks the final message word and decides where the JH '1' marker and the
// length block go.
module jh_word_pad
    import jh_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [3:0]        nbytes_i,
    input  logic [2:0]        widx_i,
    output logic [WORD_W-1:0] word_o,
    output logic [3:0]        mark_pos_o,
    output logic              mark_next_o,
    output logic              mark_in_pad_o,
    output logic              pend_len_o,
    output logic              skip_o
);

    logic [3:0] n_eff;

    always_comb begin
        n_eff  = (nbytes_i > 4'd8) ? 4'd8 : nbytes_i;
        word_o = '0;
        // Byte 0 sits in the top lane; the marker lands right after the data.
        for (int b = 0; b < 8; b++) begin
            if (4'(b) < n_eff) begin
                word_o[WORD_W-1-8*b -: 8] = word_i[WORD_W-1-8*b -: 8];
            end else if (4'(b) == n_eff) begin
                word_o[WORD_W-1-8*b -: 8] = PAD_MARK;
            end
        end
    end

    assign mark_pos_o    = n_eff;
    assign skip_o        = (n_eff == 4'd0) && (widx_i == 3'd0);
    assign mark_next_o   = (n_eff == 4'd8) && (widx_i != 3'd7);
    assign mark_in_pad_o = ((n_eff == 4'd8) && (widx_i == 3'd7)) || skip_o;
    assign pend_len_o    = !skip_o;

endmodule

// File: rtl/jh_msg_feeder.sv
// JH message front end: packs 64-bit words into 512-bit big-endian blocks,
// pads, hands blocks to the core and latches the digest.
module jh_msg_feeder
    import jh_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    jh_msg_feeder_if.slave   bus,
    output state_t           state_o
);

    state_t            state_q, state_d;
    logic [BLK_W-1:0]  buf_q, buf_d;
    logic [BLK_W-1:0]  digest_q, digest_d;
    logic [2:0]        widx_q, widx_d;
    logic [LEN_W-1:0]  bitlen_q, bitlen_d;
    logic              first_q, first_d;
    logic              final_q, final_d;
    logic              pend_len_q, pend_len_d;
    logic              mark_q, mark_d;
    logic              dvalid_q, dvalid_d;

    logic [WORD_W-1:0]      pad_word;
    logic [3:0]             pad_nbytes;
    logic                   pad_mark_next;
    logic                   pad_mark_in_pad;
    logic                   pad_pend_len;
    logic                   pad_skip;
    logic [8:0]             slot_lsb;
    logic [8:0]             next_lsb;
    logic [LEN_FIELD_W-1:0] len_field;

    jh_word_pad u_pad (
        .word_i        (bus.s_data),
        .nbytes_i      (bus.s_nbytes),
        .widx_i        (widx_q),
        .word_o        (pad_word),
        .mark_pos_o    (pad_nbytes),
        .mark_next_o   (pad_mark_next),
        .mark_in_pad_o (pad_mark_in_pad),
        .pend_len_o    (pad_pend_len),
        .skip_o        (pad_skip)
    );

    // Slot 0 occupies the top 64 bits of the block.
    assign slot_lsb  = {3'd7 - widx_q, 6'd0};
    assign next_lsb  = {3'd6 - widx_q, 6'd0};
    assign len_field = {{(LEN_FIELD_W-LEN_W){1'b0}}, bitlen_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FILL;
            buf_q      <= '0;
            digest_q   <= '0;
            widx_q     <= 3'd0;
            bitlen_q   <= '0;
            first_q    <= 1'b1;
            final_q    <= 1'b0;
            pend_len_q <= 1'b0;
            mark_q     <= 1'b0;
            dvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            digest_q   <= digest_d;
            widx_q     <= widx_d;
            bitlen_q   <= bitlen_d;
            first_q    <= first_d;
            final_q    <= final_d;
            pend_len_q <= pend_len_d;
            mark_q     <= mark_d;
            dvalid_q   <= dvalid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        digest_d   = digest_q;
        widx_d     = widx_q;
        bitlen_d   = bitlen_q;
        first_d    = first_q;
        final_d    = final_q;
        pend_len_d = pend_len_q;
        mark_d     = mark_q;
        dvalid_d   = 1'b0;

        case (state_q)
            FILL: begin
                if (bus.s_valid) begin
                    if (!bus.s_last) begin
                        buf_d[slot_lsb +: WORD_W] = bus.s_data;
                        bitlen_d = bitlen_q + LEN_W'(64);
                        widx_d   = widx_q + 3'd1;
                        if (widx_q == 3'd7) begin
                            final_d    = 1'b0;
                            pend_len_d = 1'b0;
                            state_d    = ISSUE;
                        end
                    end else if (pad_skip) begin
                        // Empty buffer: the length block is the only block left.
                        buf_d      = len_block(pad_mark_in_pad, len_field);
                        mark_d     = pad_mark_in_pad;
                        final_d    = 1'b1;
                        pend_len_d = 1'b0;
                        widx_d     = 3'd0;
                        state_d    = ISSUE;
                    end else begin
                        buf_d[slot_lsb +: WORD_W] = pad_word;
                        if (pad_mark_next) begin
                            buf_d[next_lsb +: WORD_W] = {PAD_MARK, {(WORD_W-8){1'b0}}};
                        end
                        bitlen_d   = bitlen_q + LEN_W'({pad_nbytes, 3'b000});
                        mark_d     = pad_mark_in_pad;
                        pend_len_d = pad_pend_len;
                        final_d    = 1'b0;
                        widx_d     = 3'd0;
                        state_d    = ISSUE;
                    end
                end
            end

            ISSUE: begin
                first_d = 1'b0;
                state_d = WAIT;
            end

            WAIT: begin
                if (bus.core_fin) begin
                    if (final_q) begin
                        digest_d   = bus.core_odata;
                        dvalid_d   = 1'b1;
                        first_d    = 1'b1;
                        bitlen_d   = '0;
                        buf_d      = '0;
                        widx_d     = 3'd0;
                        final_d    = 1'b0;
                        pend_len_d = 1'b0;
                        mark_d     = 1'b0;
                        state_d    = FILL;
                    end else if (pend_len_q) begin
                        buf_d      = len_block(mark_q, len_field);
                        final_d    = 1'b1;
                        pend_len_d = 1'b0;
                        state_d    = ISSUE;
                    end else begin
                        buf_d   = '0;
                        widx_d  = 3'd0;
                        state_d = FILL;
                    end
                end
            end

            default: state_d = FILL;
        endcase
    end

    assign bus.s_ready      = (state_q == FILL);
    assign bus.core_en      = (state_q == ISSUE);
    assign bus.core_init    = (state_q == ISSUE) && first_q;
    assign bus.core_blk     = buf_q;
    assign bus.digest       = digest_q;
    assign bus.digest_valid = dvalid_q;
    assign bus.busy         = !((state_q == FILL) && (widx_q == 3'd0) && first_q);
    assign state_o          = state_q;

endmodule

// File: tb/tb_jh_msg_feeder.sv
// Directed bench for jh_msg_feeder: an independent JH padding model fills the
// expected block queue, and a scripted core answers each block.
module tb_jh_msg_feeder;
    import jh_pkg::*;

    logic   clk = 1'b0;
    logic   rst;
    state_t state_o;

    jh_msg_feeder_if bus ();

    jh_msg_feeder #(.LEN_W(64)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [BLK_W-1:0] exp_q[$];
    logic             exp_init_q[$];
    logic [BLK_W-1:0] dig_q[$];

    logic [7:0] msg [0:255];
    bit         trail_empty = 1'b0;
    bit         hold_en     = 1'b0;
    bit         fin_mid_en  = 1'b0;
    int         abort_at    = -1;

    task automatic chk(input string tag, input logic [BLK_W-1:0] obs, input logic [BLK_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference JH padding: msg || 1 || 0^(383 + (-8L mod 512)) || 128-bit length.
    task automatic build_exp(input int len);
        logic [7:0]       pb [0:383];
        logic [BLK_W-1:0] blk;
        logic [63:0]      bits;
        int               t;
        t = len + 48 + ((64 - (len % 64)) % 64) + 16;
        for (int i = 0; i < 384; i++) pb[i] = 8'h00;
        for (int i = 0; i < len; i++) pb[i] = msg[i];
        pb[len] = 8'h80;
        bits = 64'(len) * 64'd8;
        for (int k = 0; k < 8; k++) pb[t-1-k] = bits[8*k +: 8];
        for (int b = 0; b < t / 64; b++) begin
            for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pb[64*b+j];
            exp_q.push_back(blk);
            exp_init_q.push_back(b == 0);
        end
    endtask

    function automatic logic [63:0] word_at(input int k, input int len);
        logic [63:0] w;
        for (int j = 0; j < 8; j++) begin
            if (8*k + j < len) w[63-8*j -: 8] = msg[8*k+j];
            else               w[63-8*j -: 8] = 8'($urandom_range(0, 255));
        end
        return w;
    endfunction

    task automatic send_word(input logic [63:0] d, input logic lst, input logic [3:0] n);
        int cnt = 0;
        bus.s_data = d; bus.s_last = lst; bus.s_nbytes = n; bus.s_valid = 1'b1;
        while (bus.s_ready !== 1'b1 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        chk("ready_latency", cnt, 0);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_nbytes = 4'd0;
    endtask

    task automatic service_block(input int delay, input bit is_final, input bit hold,
                                 input logic [63:0] hd, input logic hl, input logic [3:0] hn);
        int               lat = 0;
        logic             stable = 1'b1;
        logic [BLK_W-1:0] snap, e, od;
        logic             ei;
        while (bus.core_en !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("en_latency", lat, 0);
        e  = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        ei = (exp_init_q.size() > 0) ? exp_init_q.pop_front() : 1'bx;
        chk("core_blk", bus.core_blk, e);
        chk("core_init", bus.core_init, ei);
        snap = bus.core_blk;
        @(negedge clk);
        if (hold) begin
            bus.s_data = hd; bus.s_last = hl; bus.s_nbytes = hn; bus.s_valid = 1'b1;
        end
        repeat (delay) begin
            if (bus.core_blk !== snap || bus.s_ready !== 1'b0 || bus.core_en !== 1'b0) stable = 1'b0;
            @(negedge clk);
        end
        for (int i = 0; i < 16; i++) od[32*i +: 32] = $urandom();
        if (is_final) dig_q.push_back(od);
        bus.core_odata = od;
        bus.core_fin   = 1'b1;
        @(negedge clk);
        bus.core_fin   = 1'b0;
        chk("blk_stable", stable, 1'b1);
        if (is_final) begin
            chk("dvalid", bus.digest_valid, 1'b1);
            chk("digest", bus.digest, (dig_q.size() > 0) ? dig_q.pop_front() : 'x);
            chk("busy_idle", bus.busy, 1'b0);
            @(negedge clk);
            chk("dvalid_pulse", bus.digest_valid, 1'b0);
        end else begin
            chk("dvalid_low", bus.digest_valid, 1'b0);
        end
    endtask

    task automatic abort_block();
        int lat = 0;
        while (bus.core_en !== 1'b1 && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        chk("abort_en_latency", lat, 0);
        chk("abort_blk", bus.core_blk, (exp_q.size() > 0) ? exp_q.pop_front() : 'x);
        repeat (3) @(negedge clk);
        chk("abort_in_wait", state_o, WAIT);
        #2 rst = 1'b1;
        #1;
        chk("rst_core_en", bus.core_en, 1'b0);
        chk("rst_core_init", bus.core_init, 1'b0);
        chk("rst_core_blk", bus.core_blk, '0);
        chk("rst_digest", bus.digest, '0);
        chk("rst_dvalid", bus.digest_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_state", state_o, FILL);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_init_q.delete();
        dig_q.delete();
    endtask

    task automatic send_msg(input int len, input int delay);
        logic [63:0] words [0:31];
        logic        lasts [0:31];
        logic [3:0]  ns    [0:31];
        int          nw, nt, wib, blk_no;
        build_exp(len);
        nw = (len + 7) / 8;
        nt = 0;
        for (int k = 0; k < nw; k++) begin
            words[nt] = word_at(k, len);
            lasts[nt] = (k == nw - 1) && !trail_empty;
            ns[nt]    = lasts[nt] ? 4'(len - 8*k) : 4'd8;
            nt++;
        end
        if (len == 0 || trail_empty) begin
            words[nt] = {$urandom(), $urandom()};
            lasts[nt] = 1'b1;
            ns[nt]    = 4'd0;
            nt++;
        end
        wib = 0;
        blk_no = 0;
        for (int k = 0; k < nt; k++) begin
            send_word(words[k], lasts[k], ns[k]);
            wib++;
            if (k == 0 && !lasts[k]) chk("busy_fill", bus.busy, 1'b1);
            if (fin_mid_en && k == 1 && !lasts[k]) begin
                bus.core_fin = 1'b1;
                @(negedge clk);
                bus.core_fin = 1'b0;
                chk("fin_fill_state", state_o, FILL);
                chk("fin_fill_en", bus.core_en, 1'b0);
            end
            if (lasts[k]) begin
                while (exp_q.size() > 0) begin
                    if (blk_no == abort_at) begin
                        abort_block();
                        return;
                    end
                    service_block(delay, exp_q.size() == 1, 1'b0, 64'd0, 1'b0, 4'd0);
                    blk_no++;
                end
            end else if (wib == 8) begin
                wib = 0;
                if (blk_no == abort_at) begin
                    abort_block();
                    return;
                end
                service_block(delay, 1'b0, hold_en && (k + 1 < nt), words[k+1], lasts[k+1], ns[k+1]);
                blk_no++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.s_data = '0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.s_nbytes = 4'd0;
        bus.core_fin = 1'b0; bus.core_odata = '0;
        repeat (2) @(negedge clk);
        chk("reset_core_en", bus.core_en, 1'b0);
        chk("reset_core_init", bus.core_init, 1'b0);
        chk("reset_core_blk", bus.core_blk, '0);
        chk("reset_digest", bus.digest, '0);
        chk("reset_dvalid", bus.digest_valid, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_state", state_o, FILL);
        rst = 1'b0;
        @(negedge clk);

        // Stray core_fin while idle must not move the FSM.
        bus.core_fin = 1'b1;
        @(negedge clk);
        bus.core_fin = 1'b0;
        chk("idle_fin_state", state_o, FILL);
        chk("idle_fin_en", bus.core_en, 1'b0);
        chk("idle_fin_busy", bus.busy, 1'b0);

        // Empty message.
        send_msg(0, 3);

        // "abc".
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 2);

        // 64 and 63 byte messages.
        for (int i = 0; i < 256; i++) msg[i] = 8'($urandom_range(0, 255));
        send_msg(64, 2);
        send_msg(63, 1);

        // Exact block end signalled by an extra empty last word.
        trail_empty = 1'b1;
        send_msg(64, 0);

        // Empty last word mid-block, plus a stray core_fin during FILL.
        fin_mid_en = 1'b1;
        send_msg(16, 1);
        fin_mid_en  = 1'b0;
        trail_empty = 1'b0;

        // Backpressure: next word held valid through a 40-cycle core.
        hold_en = 1'b1;
        send_msg(72, 40);
        hold_en = 1'b0;

        // Random lengths.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) msg[i] = 8'($urandom_range(0, 255));
            send_msg($urandom_range(1, 200), $urandom_range(0, 6));
        end

        // Reset during the second block of a three-block message, then "abc".
        abort_at = 1;
        send_msg(100, 5);
        abort_at = -1;
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        send_msg(3, 0);

        repeat (2) @(negedge clk);
        chk("exp_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jh_msg_feeder.md
Name: jh_msg_feeder

Overview:
- Message-side front end for the JH hash core.
- Accepts a byte-aligned message as a 64-bit word stream and assembles 512-bit blocks, big-endian: first byte lands in blk[511:504].
- Applies JH padding: '1' bit, zeros, then a 128-bit bit-length.
- Drives the core's enable/init block interface, waits for the core's done pulse per block, and latches the core's 512-bit output after the final block.

Parameters:
- WORD_W, 64, input word width (fixed; blocks are 8 words)
- LEN_W, 64, message bit-length counter width; upper 64 bits of the 128-bit length field are zero

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- s_data  in  64  message word, first byte in [63:56]
- s_valid  in  1  s_data valid
- s_ready  out  1  feeder accepts word this cycle
- s_last  in  1  final word of message
- s_nbytes  in  4  valid bytes in last word, 0..8 (0 permits empty message / exact-block end); ignored when s_last=0
- core_en  out  1  one-cycle start pulse to core
- core_init  out  1  asserted with core_en on first block of a message
- core_blk  out  512  block to core, stable from core_en until core_fin
- core_fin  in  1  core block-complete pulse
- core_odata  in  512  core output half-state
- digest  out  512  latched core_odata after final block
- digest_valid  out  1  one-cycle pulse, digest updated
- busy  out  1  high in any state except FILL with empty buffer and no message in progress

Behaviour:
- One clock. Reset is asynchronous and active-high (rst); clock is clk.
- Reset values: all outputs 0, buffer 0, bitlen 0, first=1, state FILL.
- States:
  - FILL: s_ready=1. Each accepted word is written to word slot widx (0..7), widx++.
    - Non-last word: bitlen += 64. After slot 7 is written, go to ISSUE with final=0.
    - Last word, n=s_nbytes: bytes >= n are zeroed; bitlen += 8n.
      - n<8: byte n gets 0x80; block is partial, so set pend_len=1, mark_in_pad=0.
      - n=8 and widx<7: 0x80 goes at byte 0 of slot widx+1; pend_len=1, mark_in_pad=0.
      - n=8 and widx=7: block is exactly full; pend_len=1, mark_in_pad=1.
      - n=0 and widx=0: no data bytes in buffer, so skip the data block; go directly to the length block with mark_in_pad=1.
  - ISSUE: core_en=1 for one cycle; core_init=first; first<=0; go to WAIT.
  - WAIT: hold core_blk. On core_fin:
    - If the block was final: digest<=core_odata, digest_valid=1 next cycle, first<=1, bitlen<=0, go to FILL.
    - Else if pend_len: load length block, final=1, go to ISSUE.
    - Else: clear buffer, widx=0, go to FILL.
- Length block: all zero except bit 511 = mark_in_pad and [127:0] = {64'b0, bitlen}.
- Latency:
  - Word completing a block accepted at cycle t gives core_en at t+1.
  - core_fin at cycle t gives the next core_en at t+1 (length block) or s_ready=1 at t+1.
- Boundary rules:
  - s_ready=0 outside FILL; held s_valid is not lost.
  - core_fin outside WAIT is ignored.
  - No new message is accepted until digest_valid has fired.
  - bitlen wraps silently above 2^64-1; longer messages are unsupported.
  - rst mid-message aborts everything; the core shares rst, so the next message restarts with core_init=1.

Decomposition:
- Package jh_pkg holds:
  - BLK_W=512, WORD_W=64, LEN_FIELD_W=128
  - state enum {FILL, ISSUE, WAIT}
  - PAD_MARK=8'h80
- One combinational sub-module, jh_word_pad: inputs word, n, widx; outputs the masked word, the marker position, and the mark_in_pad / pend_len flags.

Test Plan:
- Empty message (one word, s_last=1, s_nbytes=0) -> single block, core_blk = bit511=1, rest 0, core_init=1; digest_valid the cycle after core_fin.
- "abc" (s_data=64'h6162630000000000, nbytes=3) -> blk1 [511:480]=32'h61626380, rest 0, init=1; blk2 all zero except [127:0]=128'h18, init=0; one digest_valid.
- 64-byte message (8 full words, last nbytes=8) -> blk1 = data; blk2 bit511=1, [127:0]=0x200.
- 63-byte message (last nbytes=7) -> blk1 [7:0]=8'h80; blk2 bit511=0, [127:0]=0x1F8.
- Backpressure: s_valid held high through WAIT -> s_ready=0 and no word dropped; core_fin pulsed in FILL -> no state change; core_blk constant from core_en to core_fin with a 40-cycle core delay.
- Assert rst in WAIT of 2nd block of a 3-block message -> all outputs 0 asynchronously; next message's first core_en has core_init=1, correct bitlen.
